// File: rtl/hs_result_sink_pkg.sv
// Shared definitions for the req/ack result sink and its producer-side peers.
// Holds the handshake FSM encoding and the LFSR feedback taps.
package hs_result_sink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } hs_state_t;

  // Fibonacci taps 16,14,13,11 as a bit mask over q[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] q
  );
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic longint affine(
    input longint m,
    input longint x,
    input longint a
  );
    return m * x + a;
  endfunction

endpackage

// File: rtl/hs_lfsr16.sv
// 16-bit Fibonacci LFSR used to pace request slots.
// Reloads its seed on reset and advances only when enabled.
module hs_lfsr16
  import hs_result_sink_pkg::*;
#(
  parameter logic [15:0] seed = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/hs_result_sink.sv
// Consumer end of the req/ack handshake: requests words, checks them
// against an affine golden sequence and reports counts and pass/fail.
module hs_result_sink
  import hs_result_sink_pkg::*;
#(
  parameter int          data_width    = 32,
  parameter int          max_data_size = 5000,
  parameter int          initial_value = 0,
  parameter int          exp_mul       = 3,
  parameter int          exp_add       = 2,
  parameter int          stall_thresh  = 0,
  parameter logic [15:0] lfsr_seed     = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req,
  input  logic                  ack,
  input  logic [data_width-1:0] din,
  output logic [31:0]           count,
  output logic [31:0]           err_count,
  output logic [31:0]           first_err_idx,
  output logic [data_width-1:0] first_err_data,
  output logic [31:0]           cycles,
  output logic                  proto_err,
  output logic                  done,
  output logic                  pass
);

  localparam logic [data_width-1:0] EXP0 =
    data_width'(affine(exp_mul, initial_value, exp_add));
  localparam logic [data_width-1:0] STEP =
    data_width'(exp_mul);
  localparam logic [7:0]  THRESH = 8'(stall_thresh);
  localparam logic [31:0] MAX    = 32'(max_data_size);

  hs_state_t             state;
  logic [15:0]           lfsr;
  logic [data_width-1:0] exp_q;

  logic        lfsr_en;
  logic        stall;
  logic        hit;
  logic        mism;
  logic        spur;
  logic        last;
  logic        perr_n;
  logic        done_n;
  logic        pass_n;
  logic [31:0] err_n;
  logic        unused_lfsr_hi;

  assign lfsr_en = (state != DONE);

  hs_lfsr16 #(
    .seed(lfsr_seed)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .en (lfsr_en),
    .q  (lfsr)
  );

  // Only the low 7 bits pace the slots; 128 stalls forever
  assign stall = {1'b0, lfsr[6:0]} < THRESH;
  assign unused_lfsr_hi = ^lfsr[15:7];

  assign hit    = (state == REQ) && ack;
  assign mism   = hit && (din != exp_q);
  assign spur   = ack && (state != REQ);
  assign last   = (count + 32'd1) == MAX;
  assign err_n  = err_count + {31'd0, mism};
  assign perr_n = proto_err | spur;
  assign done_n = done | (hit & last);
  assign pass_n = done_n & (err_n == 32'd0) & ~perr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req            <= 1'b0;
      exp_q          <= EXP0;
      count          <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      cycles         <= '0;
      proto_err      <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      proto_err <= perr_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;

      if (state != DONE && cycles != '1) begin
        cycles <= cycles + 32'd1;
      end

      if (mism && err_count == 32'd0) begin
        first_err_idx  <= count;
        first_err_data <= din;
      end

      if (hit) begin
        count <= count + 32'd1;
        exp_q <= exp_q + STEP;
      end

      unique case (state)
        IDLE: begin
          if (!stall) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            req   <= 1'b0;
            state <= last ? DONE : GAP;
          end
        end
        GAP: begin
          if (!stall) begin
            state <= REQ;
            req   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hs_result_sink.md
# hs_result_sink

Synthesizable consumer end of the req/ack dataflow handshake. It issues requests to an `out` operator, captures each acknowledged word and checks it against an affine golden sequence. It also counts transfers, mismatches and cycles, and raises `done`/`pass` after `max_data_size` words. It replaces the behavioural consumer in hardware benches: it connects to an `arf` `dout_req_N`/`dout_ack_N`/`dout_N` triple.

## Interface
Parameters:
- `data_width`, 32, word width; all data and golden arithmetic are modulo 2^data_width.
- `max_data_size`, 5000, number of transfers before `done`.
- `initial_value`, 0, first source value `x0` the golden model assumes.
- `exp_mul`, 3, golden slope: expected[n] = exp_mul*(x0+n) + exp_add.
- `exp_add`, 2, golden offset.
- `stall_thresh`, 0, backpressure level (0..128). Each request slot stalls when `lfsr[6:0] < stall_thresh`.
- `lfsr_seed`, 16'hACE1, 16-bit LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req` out 1: request to upstream responder.
- `ack` in 1: one-cycle acknowledge from upstream; `din` is valid in the same cycle.
- `din` in data_width: result word.
- `count` out 32: accepted transfers.
- `err_count` out 32: mismatching transfers.
- `first_err_idx` out 32: transfer index of the first mismatch.
- `first_err_data` out data_width: received value at the first mismatch.
- `cycles` out 32: clock cycles since reset, frozen at `done`.
- `proto_err` out 1: sticky; set by an `ack` seen while `req`=0.
- `done` out 1: `count` has reached `max_data_size`.
- `pass` out 1: `done` & (`err_count`==0) & ~`proto_err`.

## Operation
- FSM states:
  - `IDLE` (reset state).
  - `REQ`: `req`=1.
  - `GAP`: `req`=0, one cycle.
  - `DONE`: `req`=0 forever.
- `IDLE`→`REQ` on the first cycle after reset, unless stalled; if stalled, remain in `IDLE`.
- `REQ`: hold `req`=1 until `ack`=1 is sampled. On that edge:
  - capture `din`;
  - compare `din` with `exp`;
  - `count`+1, `exp`+=`exp_mul`;
  - go to `GAP`, or to `DONE` if the new count equals `max_data_size`.
- `GAP`→`REQ` if not stalled, else →`IDLE`. `IDLE` re-evaluates the stall condition every cycle.
- Mismatch:
  - `err_count`+1;
  - if `err_count` was 0, latch `first_err_idx` = `count` (pre-increment) and `first_err_data` = `din`.
- `exp` initialises to `exp_mul*initial_value + exp_add`, truncated to data_width, and wraps silently.
- The LFSR is a 16-bit Fibonacci LFSR with taps 16,14,13,11. It advances every cycle when not in `DONE`.
- `ack` while `req`=0 (in `IDLE`, `GAP` or `DONE`): sets `proto_err`; data is ignored and no count changes.
- `cycles` increments every cycle while not `DONE`; it saturates at 2^32-1.
- `rst` at any time: returns to `IDLE` and clears all counters, flags and `exp`; the LFSR reloads `lfsr_seed`.

## Timing
- Reset values:
  - `req`=0, `done`=0, `pass`=0, `proto_err`=0;
  - `count`=0, `err_count`=0, `first_err_idx`=0, `first_err_data`=0, `cycles`=0.
- All outputs are registered.
- `req` rises on the first edge after `rst` falls (stall_thresh=0).
- `ack` in cycle k causes `req`=0 and updated counters from edge k+1.
- The next `req` rises no earlier than edge k+2, so there is at least one idle `req` cycle between transfers.
- Throughput with stall_thresh=0 is bounded by the responder's latency plus 1 gap cycle.
- `done` and `pass` assert on the same edge that `count` reaches `max_data_size`, and stay high until `rst`.
- `ack` on the final transfer's edge is counted. A later `ack` sets `proto_err` and drops `pass` on the next edge.

## Structure
- Shared package holds the FSM state encoding (`IDLE`, `REQ`, `GAP`, `DONE`, 2 bits) and the LFSR tap constant, so producer-side models can reuse them.
- One sub-module, `hs_lfsr16`:
  - 16-bit LFSR with `clk`, `rst`, `en`, seed parameter, and `q` output;
  - shared with a future synthesizable producer.
- Golden generator, checker and counters live in the top module.

## Test plan
- Ideal responder (ack 1 cycle after `req`), `initial_value`=0, `max_data_size`=4, data 2,5,8,11 → `count`=4, `err_count`=0, `done`=`pass`=1, `req` low thereafter.
- Same responder, third word corrupted to 9 → `err_count`=1, `first_err_idx`=2, `first_err_data`=9, `pass`=0.
- Spurious `ack` pulse injected during `GAP` → `proto_err`=1, `count` unchanged, `pass`=0 at `done`.
- `stall_thresh`=128 → `req` never asserts, `cycles` increments, `count` stays 0.
- `rst` pulsed after 2 of 4 transfers → all counters return to 0 and `req` is 0 in the reset cycle. The run restarts expecting 2,5,8,11.
- `data_width`=8, `initial_value`=84 → expected first word 254, second word 1 (wrap); wrapped data checks clean and `pass`=1.
